ir_tx_scheduler: RTL and testbench
==================================

Name: ir_tx_scheduler

Overview:
- Sequences the NEC IR transmitter from keypad events.
- On a new key press it issues one full NEC frame (address, ~address, command, ~command). While the key stays held it issues NEC repeat codes on a fixed 108 ms frame grid.
- Sits between the 4x4 keypad scanner (key_valid/key_code/key_held) and the NEC encoder (tx_start/tx_ready/tx_done).
- It arbitrates a single pending key and owns all frame timing.

Parameters:
- CUSTOM_CODE, 8'h00, NEC address byte sent first (tx_data[7:0]).
- CMD_BASE, 8'h00, command = CMD_BASE + key_code (8-bit modulo add).
- FRAME_PERIOD, 5_400_000, clocks between consecutive tx_start pulses (108 ms at 50 MHz); minimum 16.
- MAX_REPEATS, 0, repeat codes per hold; 0 = unlimited.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- RST_n  in  1  asynchronous active-low reset
- key_valid  in  1  one-cycle pulse: debounced new key press
- key_code  in  4  key index 0-15, qualified by key_valid
- key_held  in  1  level: a key is currently pressed
- tx_ready  in  1  encoder idle, can accept tx_start
- tx_done  in  1  one-cycle pulse: encoder finished the current frame or repeat
- tx_start  out  1  one-cycle pulse: begin transmission
- tx_repeat  out  1  qualifies tx_start: 1 = repeat code, 0 = full frame
- tx_data  out  32  {~cmd, cmd, ~CUSTOM_CODE, CUSTOM_CODE}; bits [7:0] transmitted first
- busy  out  1  scheduler not in IDLE
- repeat_cnt  out  8  repeats issued for the current hold; saturates at 255

Behaviour:
- Reset (async, RST_n=0): all outputs 0, tx_data=0, state IDLE, pending cleared, period counter 0. Asserting reset mid-transmission drops tx_start immediately. No frame is retried after reset.
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- Pending register: key_valid latches key_code and sets pend in any state. A later key_valid overwrites it (latest key wins, single entry).
- IDLE:
  - If pend=1, go to ISSUE with frame mode.
  - busy=0.
- ISSUE:
  - tx_start=1 for exactly one cycle, in the first cycle tx_ready=1. Stay in ISSUE while tx_ready=0.
  - Frame mode: tx_repeat=0. tx_data is loaded from the pending code in the same cycle, pend cleared, repeat_cnt cleared to 0.
  - Repeat mode: tx_repeat=1, tx_data unchanged, repeat_cnt incremented.
  - Period counter resets to 0 on the tx_start cycle. Next state is WAIT_DONE.
- WAIT_DONE:
  - Wait for tx_done. tx_done in the same cycle as tx_start is ignored.
  - On tx_done, go to GAP.
- GAP (period counter increments every cycle from tx_start), evaluated each cycle, highest priority first:
  1. pend=1: go to ISSUE in frame mode once counter ≥ FRAME_PERIOD-1. A new key waits for the grid and is never sent early.
  2. key_held=0: go to IDLE immediately.
  3. MAX_REPEATS≠0 and repeat_cnt==MAX_REPEATS: go to IDLE once key_held=0. Stay silent until then.
  4. Otherwise: go to ISSUE in repeat mode once counter ≥ FRAME_PERIOD-1.
- tx_start spacing: consecutive tx_start pulses are exactly FRAME_PERIOD cycles apart when tx_ready is already 1. Otherwise the start is delayed until tx_ready=1 and the grid restarts from that start.
- Counter: 23 bits, saturates at FRAME_PERIOD-1, never wraps.
- Simultaneous events:
  - key_valid in the same cycle as a frame-mode load: the new code becomes pend; the loaded frame uses the old pending value.
  - key_valid and tx_done in the same cycle: both are honoured.
- key_held falling during WAIT_DONE: the current transmission completes, then GAP exits to IDLE.
- Latency: pend set in IDLE with tx_ready=1 → tx_start 2 cycles after key_valid.
- tx_data, tx_repeat and repeat_cnt hold their value until the next ISSUE load.

Test Plan (FRAME_PERIOD=1000; encoder model: tx_ready=1, tx_done 300 cycles after tx_start):
- Reset then idle; key_valid with code 0, key_held held 0 → one tx_start, tx_repeat=0, tx_data=32'hFF00FF00. No further starts, busy returns 0 after tx_done.
- key_valid code 6 with CMD_BASE=8'h10, key_held high for 3500 cycles → frame tx_data=32'hE916FF00, then repeats at +1000/+2000/+3000 cycles with tx_repeat=1. repeat_cnt=3, then IDLE.
- MAX_REPEATS=2, key 9 held 5000 cycles → exactly 1 frame + 2 repeats. busy stays 1 until key_held falls, then 0.
- key 3 held; key_valid code 12 at cycle 400 after the frame start → next start at exactly +1000 is a full frame with cmd 8'h0C and repeat_cnt=0.
- tx_ready forced 0 for 200 cycles around the repeat due point → tx_start at the first ready cycle; next repeat 1000 cycles after that.
- RST_n pulsed low during WAIT_DONE → all outputs 0 asynchronously. After release, no tx_start until a new key_valid.

Source files
------------

// File: rtl/ir_tx_scheduler.sv
// NEC IR transmit scheduler: turns keypad events into full frames and
// repeat codes on a fixed frame grid, and hands them to the NEC encoder.
module ir_tx_scheduler #(
    parameter logic [7:0]  CUSTOM_CODE  = 8'h00,
    parameter logic [7:0]  CMD_BASE     = 8'h00,
    parameter int unsigned FRAME_PERIOD = 5_400_000,
    parameter int unsigned MAX_REPEATS  = 0
) (
    input  logic        CLOCK_50,
    input  logic        RST_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        key_held,
    input  logic        tx_ready,
    input  logic        tx_done,
    output logic        tx_start,
    output logic        tx_repeat,
    output logic [31:0] tx_data,
    output logic        busy,
    output logic [7:0]  repeat_cnt
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StGap} state_t;

    localparam logic [22:0] CntMax = 23'(FRAME_PERIOD - 1);

    state_t      r_state;
    logic        r_pend;
    logic [3:0]  r_pend_code;
    logic [22:0] r_cnt;
    logic        r_tx_repeat;
    logic [31:0] r_tx_data;
    logic [7:0]  r_repeat_cnt;

    logic        w_tx_start;
    logic        w_cnt_due;
    logic        w_rep_limit;
    logic        w_load_frame;
    logic        w_load_repeat;
    logic [7:0]  w_cmd;
    logic [31:0] w_frame_data;

    assign w_tx_start   = (r_state == StIssue) && tx_ready;
    assign w_cnt_due    = (r_cnt >= CntMax);
    assign w_rep_limit  = (MAX_REPEATS != 0) && ({24'd0, r_repeat_cnt} == MAX_REPEATS);
    assign w_cmd        = CMD_BASE + {4'd0, r_pend_code};
    assign w_frame_data = {~w_cmd, w_cmd, ~CUSTOM_CODE, CUSTOM_CODE};

    // Frame/repeat payload is loaded on entry to ISSUE so it is already valid
    // while tx_start is high. A pending key always beats a repeat, but only on
    // the grid; without a pending key a released key ends the hold at once.
    assign w_load_frame  = ((r_state == StIdle) && r_pend) ||
                           ((r_state == StGap) && r_pend && w_cnt_due);
    assign w_load_repeat = (r_state == StGap) && !r_pend && key_held &&
                           !w_rep_limit && w_cnt_due;

    // Scheduler FSM, pending-key register, frame grid counter and payload.
    always_ff @(posedge CLOCK_50 or negedge RST_n) begin
        if (!RST_n) begin
            r_state      <= StIdle;
            r_pend       <= 1'b0;
            r_pend_code  <= 4'd0;
            r_cnt        <= 23'd0;
            r_tx_repeat  <= 1'b0;
            r_tx_data    <= 32'd0;
            r_repeat_cnt <= 8'd0;
        end else begin
            // Counter reads 0 in the tx_start cycle, so it is 1 one cycle later.
            if (w_tx_start) begin
                r_cnt <= 23'd1;
            end else if (!w_cnt_due) begin
                r_cnt <= r_cnt + 23'd1;
            end

            // A fresh key press wins over the clear from a simultaneous load.
            if (key_valid) begin
                r_pend      <= 1'b1;
                r_pend_code <= key_code;
            end else if (w_load_frame) begin
                r_pend <= 1'b0;
            end

            if (w_load_frame) begin
                r_tx_data    <= w_frame_data;
                r_tx_repeat  <= 1'b0;
                r_repeat_cnt <= 8'd0;
            end else if (w_load_repeat) begin
                r_tx_repeat <= 1'b1;
                if (r_repeat_cnt != 8'hFF) begin
                    r_repeat_cnt <= r_repeat_cnt + 8'd1;
                end
            end

            case (r_state)
                StIdle: begin
                    if (w_load_frame) begin
                        r_state <= StIssue;
                    end
                end
                StIssue: begin
                    if (tx_ready) begin
                        r_state <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (tx_done) begin
                        r_state <= StGap;
                    end
                end
                StGap: begin
                    if (w_load_frame || w_load_repeat) begin
                        r_state <= StIssue;
                    end else if (!r_pend && !key_held) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign tx_start   = w_tx_start;
    assign tx_repeat  = r_tx_repeat;
    assign tx_data    = r_tx_data;
    assign busy       = (r_state != StIdle);
    assign repeat_cnt = r_repeat_cnt;

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Bench for ir_tx_scheduler: three parameterisations, an encoder model that
// returns tx_done 300 cycles after each start, and a start scoreboard.
module tb_ir_tx_scheduler;

    localparam int unsigned FP      = 1000;
    localparam int unsigned DoneLat = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  key_valid;
    logic [2:0]  key_held;
    logic [2:0]  tx_ready;
    logic [2:0]  tx_done;
    logic [2:0]  tx_start;
    logic [2:0]  tx_repeat;
    logic [2:0]  busy;
    logic [3:0]  key_code   [3];
    logic [31:0] tx_data    [3];
    logic [7:0]  repeat_cnt [3];

    always #5 clk = ~clk;

    // Instance 0: plain; 1: CMD_BASE=0x10; 2: MAX_REPEATS=2.
    ir_tx_scheduler #(.CUSTOM_CODE(8'h00), .CMD_BASE(8'h00), .FRAME_PERIOD(FP), .MAX_REPEATS(0))
    u_dut_a (
        .CLOCK_50(clk), .RST_n(rst_n), .key_valid(key_valid[0]), .key_code(key_code[0]),
        .key_held(key_held[0]), .tx_ready(tx_ready[0]), .tx_done(tx_done[0]),
        .tx_start(tx_start[0]), .tx_repeat(tx_repeat[0]), .tx_data(tx_data[0]),
        .busy(busy[0]), .repeat_cnt(repeat_cnt[0])
    );

    ir_tx_scheduler #(.CUSTOM_CODE(8'h00), .CMD_BASE(8'h10), .FRAME_PERIOD(FP), .MAX_REPEATS(0))
    u_dut_b (
        .CLOCK_50(clk), .RST_n(rst_n), .key_valid(key_valid[1]), .key_code(key_code[1]),
        .key_held(key_held[1]), .tx_ready(tx_ready[1]), .tx_done(tx_done[1]),
        .tx_start(tx_start[1]), .tx_repeat(tx_repeat[1]), .tx_data(tx_data[1]),
        .busy(busy[1]), .repeat_cnt(repeat_cnt[1])
    );

    ir_tx_scheduler #(.CUSTOM_CODE(8'h00), .CMD_BASE(8'h00), .FRAME_PERIOD(FP), .MAX_REPEATS(2))
    u_dut_c (
        .CLOCK_50(clk), .RST_n(rst_n), .key_valid(key_valid[2]), .key_code(key_code[2]),
        .key_held(key_held[2]), .tx_ready(tx_ready[2]), .tx_done(tx_done[2]),
        .tx_start(tx_start[2]), .tx_repeat(tx_repeat[2]), .tx_data(tx_data[2]),
        .busy(busy[2]), .repeat_cnt(repeat_cnt[2])
    );

    typedef struct {
        int          inst;
        int unsigned at;
        logic        rep;
        logic [31:0] data;
        logic [7:0]  rcnt;
    } exp_t;

    typedef struct {
        int          inst;
        logic [3:0]  code;
        int unsigned hold;
        logic [31:0] data;
        int unsigned reps;
    } vec_t;

    exp_t        sb [$];
    vec_t        vecs [5];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_starts = 0;
    int unsigned start_at [3] = '{0, 0, 0};
    logic [2:0]  armed = 3'b000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) tick();
    endtask

    task automatic push(input int inst, input int unsigned at, input logic rep,
                        input logic [31:0] data, input logic [7:0] rcnt);
        exp_t e;
        e.inst = inst;
        e.at   = at;
        e.rep  = rep;
        e.data = data;
        e.rcnt = rcnt;
        sb.push_back(e);
    endtask

    // Scoreboard: every observed start must match the oldest expected start.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (tx_start[i] === 1'b1) begin
                n_starts++;
                start_at[i] = cyc;
                armed[i] = 1'b1;
                chk("start_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("start_inst", i, e.inst);
                    chk("start_cycle", cyc, e.at);
                    chk("start_tx_repeat", 32'(tx_repeat[i]), 32'(e.rep));
                    chk("start_tx_data", tx_data[i], e.data);
                    chk("start_repeat_cnt", 32'(repeat_cnt[i]), 32'(e.rcnt));
                end
            end
        end
    end

    // Encoder model: one-cycle tx_done exactly DoneLat cycles after a start.
    initial begin
        tx_done = 3'b000;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                tx_done[i] = armed[i] && (cyc == start_at[i] + DoneLat);
            end
        end
    end

    initial begin
        int unsigned c;
        int unsigned s;
        int unsigned stop;
        int          starts_before;

        vecs[0] = '{inst: 0, code: 4'd0,  hold: 0,    data: 32'hFF00FF00, reps: 0};
        vecs[1] = '{inst: 1, code: 4'd6,  hold: 3500, data: 32'hE916FF00, reps: 3};
        vecs[2] = '{inst: 2, code: 4'd9,  hold: 5000, data: 32'hF609FF00, reps: 2};
        vecs[3] = '{inst: 0, code: 4'd5,  hold: 1500, data: 32'hFA05FF00, reps: 1};
        vecs[4] = '{inst: 1, code: 4'd15, hold: 2100, data: 32'hE01FFF00, reps: 2};

        rst_n     = 1'b0;
        key_valid = 3'b000;
        key_held  = 3'b000;
        tx_ready  = 3'b111;
        for (int i = 0; i < 3; i++) key_code[i] = 4'd0;

        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk("reset_tx_start", 32'(tx_start[i]), 32'd0);
            chk("reset_busy", 32'(busy[i]), 32'd0);
            chk("reset_tx_data", tx_data[i], 32'd0);
            chk("reset_repeat_cnt", 32'(repeat_cnt[i]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (3) tick();

        // Press / hold / release vectors.
        for (int v = 0; v < 5; v++) begin
            c = cyc;
            key_valid[vecs[v].inst] = 1'b1;
            key_code[vecs[v].inst]  = vecs[v].code;
            key_held[vecs[v].inst]  = (vecs[v].hold != 0);
            push(vecs[v].inst, c + 2, 1'b0, vecs[v].data, 8'd0);
            for (int k = 1; k <= int'(vecs[v].reps); k++) begin
                push(vecs[v].inst, c + 2 + FP * k, 1'b1, vecs[v].data, 8'(k));
            end
            tick();
            key_valid[vecs[v].inst] = 1'b0;
            if (vecs[v].hold != 0) begin
                wait_until(c + vecs[v].hold - 1);
                chk("busy_while_held", 32'(busy[vecs[v].inst]), 32'd1);
                tick();
                key_held[vecs[v].inst] = 1'b0;
            end
            stop = c + 2 + FP * vecs[v].reps + DoneLat;
            if (c + vecs[v].hold > stop) stop = c + vecs[v].hold;
            wait_until(stop + FP + 10);
            chk("busy_after_release", 32'(busy[vecs[v].inst]), 32'd0);
            chk("sb_drained", sb.size(), 32'd0);
            chk("final_repeat_cnt", 32'(repeat_cnt[vecs[v].inst]), vecs[v].reps);
            chk("final_tx_repeat", 32'(tx_repeat[vecs[v].inst]), 32'(vecs[v].reps != 0));
        end

        // New key while holding: waits for the grid, then goes out as a full frame.
        c = cyc;
        s = c + 2;
        key_valid[0] = 1'b1;
        key_code[0]  = 4'd3;
        key_held[0]  = 1'b1;
        push(0, s, 1'b0, 32'hFC03FF00, 8'd0);
        push(0, s + FP, 1'b0, 32'hF30CFF00, 8'd0);
        tick();
        key_valid[0] = 1'b0;
        wait_until(s + 400);
        key_valid[0] = 1'b1;
        key_code[0]  = 4'd12;
        tick();
        key_valid[0] = 1'b0;
        wait_until(s + 1500);
        key_held[0] = 1'b0;
        wait_until(s + 1500 + FP + 10);
        chk("override_sb_drained", sb.size(), 32'd0);
        chk("override_busy", 32'(busy[0]), 32'd0);

        // Encoder busy across the due point: start slips, grid restarts from it.
        c = cyc;
        s = c + 2;
        key_valid[0] = 1'b1;
        key_code[0]  = 4'd7;
        key_held[0]  = 1'b1;
        push(0, s, 1'b0, 32'hF807FF00, 8'd0);
        push(0, s + 1100, 1'b1, 32'hF807FF00, 8'd1);
        push(0, s + 2100, 1'b1, 32'hF807FF00, 8'd2);
        tick();
        key_valid[0] = 1'b0;
        wait_until(s + 900);
        tx_ready[0] = 1'b0;
        wait_until(s + 1050);
        chk("stall_busy", 32'(busy[0]), 32'd1);
        chk("stall_no_start", 32'(tx_start[0]), 32'd0);
        wait_until(s + 1100);
        tx_ready[0] = 1'b1;
        wait_until(s + 2500);
        key_held[0] = 1'b0;
        wait_until(s + 2500 + FP + 10);
        chk("stall_sb_drained", sb.size(), 32'd0);
        chk("stall_repeat_cnt", 32'(repeat_cnt[0]), 32'd2);

        // Reset during WAIT_DONE: outputs clear at once, nothing resumes.
        c = cyc;
        s = c + 2;
        key_valid[0] = 1'b1;
        key_code[0]  = 4'd2;
        key_held[0]  = 1'b1;
        push(0, s, 1'b0, 32'hFD02FF00, 8'd0);
        tick();
        key_valid[0] = 1'b0;
        wait_until(s + 100);
        chk("pre_reset_busy", 32'(busy[0]), 32'd1);
        chk("pre_reset_tx_data", tx_data[0], 32'hFD02FF00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx_start", 32'(tx_start[0]), 32'd0);
        chk("async_reset_busy", 32'(busy[0]), 32'd0);
        chk("async_reset_tx_data", tx_data[0], 32'd0);
        chk("async_reset_tx_repeat", 32'(tx_repeat[0]), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        starts_before = n_starts;
        wait_until(s + 100 + 1600);
        chk("no_start_after_reset", n_starts, starts_before);
        chk("idle_after_reset", 32'(busy[0]), 32'd0);
        key_held[0] = 1'b0;
        repeat (5) tick();
        chk("final_sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
